// File: rtl/zprize_mul_pkg.sv
// Shared types and elaboration helpers for the pipelined limb multiplier.
package zprize_mul_pkg;

    typedef enum logic [1:0] {
        MUL_FULL = 2'd0,
        MUL_SQR  = 2'd1,
        MUL_LO   = 2'd2,
        MUL_RSV  = 2'd3
    } mul_mode_t;

    function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    // Pipeline depth: operand reg, limb products, reduction levels, final add.
    function automatic int unsigned mul_lat(input int unsigned w1, input int unsigned lw1);
        return 32'd3 + 32'($clog2(ceil_div(w1, lw1)));
    endfunction

endpackage

// File: rtl/zprize_mul_limb.sv
// One registered LW0 x LW1 unsigned limb product with clock enable (maps to a single DSP).
module zprize_mul_limb #(
    parameter int unsigned LW0 = 26,
    parameter int unsigned LW1 = 17
) (
    input  logic                 clk,
    input  logic                 i_en,
    input  logic [LW0-1:0]       i_a,
    input  logic [LW1-1:0]       i_b,
    output logic [LW0+LW1-1:0]   o_p
);

    localparam int unsigned PW = LW0 + LW1;

    logic [PW-1:0] r_p;

    // Product register; data path only, so no reset.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_p <= PW'(i_a) * PW'(i_b);
        end
    end

    assign o_p = r_p;

endmodule

// File: rtl/zprize_mul_pipe_vld.sv
// Fully pipelined W0 x W1 unsigned multiplier with valid/ready back-pressure,
// per-beat mode (full / square / low half) and a metadata sideband.
// Partial products are split per in1 limb into an even-in0-limb row and an
// odd-in0-limb row; within a row the terms never overlap when LW0 >= LW1, so
// rows are formed by OR. The two row families are reduced in parallel trees
// and merged by a single carry-propagate add in the last stage. Needs N1 >= 2.
module zprize_mul_pipe_vld
    import zprize_mul_pkg::*;
#(
    parameter int unsigned W0  = 384,
    parameter int unsigned W1  = 384,
    parameter int unsigned LW0 = 26,
    parameter int unsigned LW1 = 17,
    parameter int unsigned M   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       mode_i,
    input  logic [W0-1:0]    in0,
    input  logic [W1-1:0]    in1,
    input  logic [M-1:0]     m_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W0+W1-1:0] out0,
    output logic [M-1:0]     m_o,
    output logic             busy
);

    localparam int unsigned N0  = ceil_div(W0, LW0);
    localparam int unsigned N1  = ceil_div(W1, LW1);
    localparam int unsigned LAT = mul_lat(W1, LW1);
    localparam int unsigned NL  = LAT - 3;
    localparam int unsigned NP  = 32'd1 << NL;
    localparam int unsigned P   = W0 + W1;
    localparam int unsigned PW  = LW0 + LW1;

    logic                 w_en;
    logic [LAT-1:0]       r_vld;
    logic [LAT-1:0]       w_vld_nxt;
    logic                 r_busy;
    mul_mode_t            r_mode [LAT-1];
    logic [M-1:0]         r_meta [LAT-1];
    logic [W0-1:0]        r_a;
    logic [W1-1:0]        r_b;
    logic [N0*LW0-1:0]    w_a_pad;
    logic [N1*LW1-1:0]    w_b_pad;
    logic [PW-1:0]        w_pp   [N0][N1];
    logic [P-1:0]         w_row_e [NP];
    logic [P-1:0]         w_row_o [NP];
    logic [P-1:0]         r_tr_e [NP-1];
    logic [P-1:0]         r_tr_o [NP-1];
    logic [P-1:0]         w_fin;
    logic [P-1:0]         r_out0;
    logic [M-1:0]         r_m_o;

    // Global stage enable: everything freezes while the output is held.
    assign w_en      = !(r_vld[LAT-1] && !out_ready);
    assign in_ready  = w_en;
    assign out_valid = r_vld[LAT-1];
    assign out0      = r_out0;
    assign m_o       = r_m_o;
    assign busy      = r_busy;

    // Next valid vector: shift with bubbles when enabled, hold otherwise.
    always_comb begin
        w_vld_nxt = r_vld;
        if (w_en) begin
            w_vld_nxt = {r_vld[LAT-2:0], in_valid};
        end
    end

    // Valid shift register and busy flag; the only control state that is reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld  <= '0;
            r_busy <= 1'b0;
        end else begin
            r_vld  <= w_vld_nxt;
            r_busy <= |w_vld_nxt;
        end
    end

    // Stage 0 operand capture (SQR duplicates in0) plus mode/meta shift register.
    always_ff @(posedge clk) begin
        if (w_en) begin
            r_a       <= in0;
            r_b       <= (mul_mode_t'(mode_i) == MUL_SQR) ? W1'(in0) : in1;
            r_mode[0] <= mul_mode_t'(mode_i);
            r_meta[0] <= m_i;
            for (int s = 1; s < int'(LAT) - 1; s++) begin
                r_mode[s] <= r_mode[s-1];
                r_meta[s] <= r_meta[s-1];
            end
        end
    end

    assign w_a_pad = (N0*LW0)'(r_a);
    assign w_b_pad = (N1*LW1)'(r_b);

    // Stage 1: limb partial products.
    for (genvar i = 0; i < N0; i++) begin : g_a
        for (genvar j = 0; j < N1; j++) begin : g_b
            zprize_mul_limb #(
                .LW0 (LW0),
                .LW1 (LW1)
            ) u_limb (
                .clk  (clk),
                .i_en (w_en),
                .i_a  (w_a_pad[i*LW0 +: LW0]),
                .i_b  (w_b_pad[j*LW1 +: LW1]),
                .o_p  (w_pp[i][j])
            );
        end
    end

    // Column-aligned rows: one even and one odd row per in1 limb, padded to NP rows.
    always_comb begin
        for (int j = 0; j < int'(NP); j++) begin
            w_row_e[j] = '0;
            w_row_o[j] = '0;
        end
        for (int j = 0; j < int'(N1); j++) begin
            for (int i = 0; i < int'(N0); i++) begin
                if ((i % 2) == 0) begin
                    w_row_e[j] = w_row_e[j] | (P'(w_pp[i][j]) << (i*int'(LW0) + j*int'(LW1)));
                end else begin
                    w_row_o[j] = w_row_o[j] | (P'(w_pp[i][j]) << (i*int'(LW0) + j*int'(LW1)));
                end
            end
        end
    end

    // Reduction tree: level l holds NP>>l nodes at offset NP - (2*NP>>l) in r_tr_*.
    for (genvar l = 1; l <= NL; l++) begin : g_lvl
        localparam int unsigned CNT = NP >> l;
        localparam int unsigned OFF = NP - ((2*NP) >> l);
        for (genvar k = 0; k < CNT; k++) begin : g_node
            if (l == 1) begin : g_leaf
                // First level sums adjacent rows.
                always_ff @(posedge clk) begin
                    if (w_en) begin
                        r_tr_e[OFF+k] <= w_row_e[2*k] + w_row_e[2*k+1];
                        r_tr_o[OFF+k] <= w_row_o[2*k] + w_row_o[2*k+1];
                    end
                end
            end else begin : g_inner
                localparam int unsigned POFF = NP - ((4*NP) >> l);
                // Upper levels sum adjacent nodes of the previous level.
                always_ff @(posedge clk) begin
                    if (w_en) begin
                        r_tr_e[OFF+k] <= r_tr_e[POFF+2*k] + r_tr_e[POFF+2*k+1];
                        r_tr_o[OFF+k] <= r_tr_o[POFF+2*k] + r_tr_o[POFF+2*k+1];
                    end
                end
            end
        end
    end

    assign w_fin = r_tr_e[NP-2] + r_tr_o[NP-2];

    // Final stage: carry-propagate add, LO masking, output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out0 <= '0;
            r_m_o  <= '0;
        end else if (w_en) begin
            r_out0 <= (r_mode[LAT-2] == MUL_LO) ? {W1'(0), w_fin[W0-1:0]} : w_fin;
            r_m_o  <= r_meta[LAT-2];
        end
    end

endmodule

// File: tb/tb_zprize_mul_pipe_vld.sv
// Scoreboard bench for zprize_mul_pipe_vld: a 384-bit instance and a 48-bit instance.
module tb_zprize_mul_pipe_vld;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   mode_i;
    logic [383:0] in0, in1;
    logic [31:0]  m_i;
    logic         out_valid;
    logic         out_ready;
    logic [767:0] out0;
    logic [31:0]  m_o;
    logic         busy;

    logic         in_valid_s;
    logic         in_ready_s;
    logic [1:0]   mode_s;
    logic [47:0]  a_s, b_s;
    logic [7:0]   m_s;
    logic         out_valid_s;
    logic [95:0]  out0_s;
    logic [7:0]   m_o_s;
    logic         busy_s;

    logic         rnd_ready;
    int           n_tests = 0;
    int           n_fail  = 0;

    logic [767:0] q_exp [$];
    logic [31:0]  q_meta[$];
    logic [95:0]  q_s   [$];
    logic [7:0]   qm_s  [$];

    always #5 clk = ~clk;

    zprize_mul_pipe_vld u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .mode_i(mode_i), .in0(in0), .in1(in1), .m_i(m_i),
        .out_valid(out_valid), .out_ready(out_ready), .out0(out0), .m_o(m_o), .busy(busy)
    );

    zprize_mul_pipe_vld #(.W0(48), .W1(48), .LW0(26), .LW1(17), .M(8)) u_small (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .mode_i(mode_s), .in0(a_s), .in1(b_s), .m_i(m_s),
        .out_valid(out_valid_s), .out_ready(out_ready), .out0(out0_s), .m_o(m_o_s), .busy(busy_s)
    );

    task automatic chk(input string nm, input logic [767:0] act, input logic [767:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [767:0] ref_mul(input logic [1:0] md, input logic [383:0] a,
                                             input logic [383:0] b, input int w0);
        logic [767:0] p;
        if (md == 2'd1) p = 768'(a) * 768'(a);
        else            p = 768'(a) * 768'(b);
        if (md == 2'd2) p = p & ((768'(1) << w0) - 768'(1));
        return p;
    endfunction

    function automatic logic [383:0] rand384();
        logic [383:0] r = '0;
        for (int k = 0; k < 12; k++) r = (r << 32) | 384'($urandom());
        return r;
    endfunction

    // Issue one beat to the wide instance; expected value is queued on acceptance.
    task automatic send(input logic [1:0] md, input logic [383:0] a, input logic [383:0] b,
                        input logic [31:0] m, input logic [767:0] exp);
        int guard = 0;
        bit ok = 1'b0;
        in_valid = 1'b1; mode_i = md; in0 = a; in1 = b; m_i = m;
        while (guard < 1000) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
            guard++;
        end
        if (!ok) begin
            chk("send_timeout", 768'(0), 768'(1));
        end else begin
            @(posedge clk);
            q_exp.push_back(exp);
            q_meta.push_back(m);
        end
        #1 in_valid = 1'b0;
    endtask

    // Issue one beat to the 48-bit instance.
    task automatic send_s(input logic [1:0] md, input logic [47:0] a, input logic [47:0] b,
                          input logic [7:0] m);
        logic [767:0] e;
        int guard = 0;
        bit ok = 1'b0;
        e = ref_mul(md, 384'(a), 384'(b), 48);
        in_valid_s = 1'b1; mode_s = md; a_s = a; b_s = b; m_s = m;
        while (guard < 1000) begin
            @(negedge clk);
            if (in_ready_s) begin ok = 1'b1; break; end
            guard++;
        end
        if (!ok) begin
            chk("send_s_timeout", 768'(0), 768'(1));
        end else begin
            @(posedge clk);
            q_s.push_back(e[95:0]);
            qm_s.push_back(m);
        end
        #1 in_valid_s = 1'b0;
    endtask

    // Wait for both scoreboards to empty, then confirm the pipes are idle.
    task automatic drain();
        int cyc = 0;
        while ((q_exp.size() != 0 || q_s.size() != 0) && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        if (cyc >= 3000) chk("drain_timeout", 768'(q_exp.size() + q_s.size()), 768'(0));
        repeat (12) @(posedge clk);
        #1;
        chk("idle_busy",      768'(busy),        768'(0));
        chk("idle_out_valid", 768'(out_valid),   768'(0));
        chk("idle_busy_s",    768'(busy_s),      768'(0));
    endtask

    // Output ready pattern: random ~30% low when enabled, otherwise always ready.
    always @(posedge clk) begin
        #1;
        out_ready = rnd_ready ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end

    // Monitor for the wide instance: compares every presented beat, pops on handshake.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (q_exp.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL big_unexpected: out_valid=1 with nothing outstanding, out0=%0h", out0);
            end else begin
                chk("big_out0", out0, q_exp[0]);
                chk("big_m_o", 768'(m_o), 768'(q_meta[0]));
                if (out_ready) begin
                    void'(q_exp.pop_front());
                    void'(q_meta.pop_front());
                end
            end
        end
    end

    // Monitor for the 48-bit instance.
    always @(negedge clk) begin
        if (rst_n && out_valid_s) begin
            if (q_s.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL small_unexpected: out_valid=1 with nothing outstanding, out0=%0h", out0_s);
            end else begin
                chk("small_out0", 768'(out0_s), 768'(q_s[0]));
                chk("small_m_o", 768'(m_o_s), 768'(qm_s[0]));
                if (out_ready) begin
                    void'(q_s.pop_front());
                    void'(qm_s.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [383:0] x, y, ones;
        logic [767:0] e;
        logic [1:0]   md;

        rst_n = 1'b0; in_valid = 1'b0; mode_i = 2'd0; in0 = '0; in1 = '0; m_i = '0;
        in_valid_s = 1'b0; mode_s = 2'd0; a_s = '0; b_s = '0; m_s = '0;
        out_ready = 1'b1; rnd_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 768'(out_valid), 768'(0));
        chk("rst_busy",      768'(busy),      768'(0));
        chk("rst_out0",      out0,            768'(0));
        chk("rst_m_o",       768'(m_o),       768'(0));
        chk("rst_out_valid_s", 768'(out_valid_s), 768'(0));
        @(negedge clk) rst_n = 1'b1;
        #1 chk("rel_in_ready", 768'(in_ready), 768'(1));
        @(posedge clk); #1;

        // Single MUL beat
        send(2'd0, 384'd3, 384'd5, 32'hA5, 768'd15);
        drain();

        // All-ones operands: (2^384-1)^2 = 2^768 - 2^385 + 1
        ones = '1;
        e = {{383{1'b1}}, {384{1'b0}}, 1'b1};
        send(2'd0, ones, ones, 32'h1, e);

        // Mode coverage with in0 = 2^200+7, in1 = 2^190+3
        x = (384'(1) << 200) + 384'd7;
        y = (384'(1) << 190) + 384'd3;
        send(2'd0, x, y, 32'h2,
             (768'(1) << 390) + (768'(3) << 200) + (768'(7) << 190) + 768'd21);
        send(2'd2, x, y, 32'h3,
             (768'(3) << 200) + (768'(7) << 190) + 768'd21);
        send(2'd1, x, y, 32'h4,
             (768'(1) << 400) + (768'(14) << 200) + 768'd49);
        send(2'd3, 384'd3, 384'd5, 32'h5, 768'd15);
        send(2'd2, ones, ones, 32'h6, 768'd1);
        drain();

        // Back-to-back random beats under random back-pressure
        rnd_ready = 1'b1;
        for (int n = 0; n < 64; n++) begin
            md = 2'($urandom_range(0, 3));
            x = rand384();
            y = rand384();
            send(md, x, y, 32'(n) ^ 32'hC0DE0000, ref_mul(md, x, y, 384));
        end
        rnd_ready = 1'b0;
        drain();

        // Reset with LAT-1 = 7 beats in flight
        for (int n = 0; n < 7; n++) begin
            send(2'd0, 384'(n + 1), 384'd1000, 32'(n), 768'(n + 1) * 768'd1000);
        end
        rst_n = 1'b0;
        q_exp.delete();
        q_meta.delete();
        #1;
        chk("midrst_out_valid", 768'(out_valid), 768'(0));
        chk("midrst_busy",      768'(busy),      768'(0));
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        #1 chk("midrst_in_ready", 768'(in_ready), 768'(1));
        @(posedge clk); #1;
        send(2'd0, 384'h1234, 384'h10, 32'h77, 768'h12340);
        drain();

        // 48-bit instance with non-multiple limb widths
        send_s(2'd0, '1, '1, 8'h11);
        send_s(2'd2, '1, '1, 8'h12);
        send_s(2'd1, 48'hFFFF_FFFF_FFFF, 48'h0, 8'h13);
        rnd_ready = 1'b1;
        for (int n = 0; n < 24; n++) begin
            send_s(2'($urandom_range(0, 3)), {$urandom(), 16'($urandom())},
                   {$urandom(), 16'($urandom())}, 8'(n));
        end
        rnd_ready = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
